// File: rtl/rom_region_loader.sv
// rom_region_loader: steers the hps_io ioctl ROM download into SDRAM or BRAM.
// The stream starts with a header of NUM_REGIONS big-endian 16-bit lengths
// (KiB units), followed by each region's payload in table order. Each region
// carries an SDRAM base, an optional low-address-bit reorder and a BRAM
// chip-select; a nonzero chip-select sends that region's bytes to BRAM.
//
// Handshakes: the SDRAM side is req/ack. sdr_req is a level that rises one
// cycle after the accepted ioctl_wr. sdr_addr/sdr_data/sdr_be stay frozen
// while it is high. The write completes on the cycle sdr_ack is sampled high,
// and sdr_req drops on the following edge. ioctl_wait is high for exactly the
// same cycles as sdr_req, and any ioctl_wr that arrives in that window is
// dropped. bram_wr and load_done are single-cycle strobes with no handshake.
module rom_region_loader #(
  parameter int NUM_REGIONS  = 8,
  parameter int ADDR_W       = 25,
  parameter int CS_W         = 5,
  parameter int REORDER_BITS = 3
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_REGIONS*(ADDR_W+1+CS_W)-1:0] region_tbl,
  input  logic                                   ioctl_download,
  input  logic                                   ioctl_wr,
  input  logic [7:0]                             ioctl_dout,
  output logic                                   ioctl_wait,
  output logic                                   sdr_req,
  input  logic                                   sdr_ack,
  output logic [ADDR_W-1:0]                      sdr_addr,
  output logic [15:0]                            sdr_data,
  output logic [1:0]                             sdr_be,
  output logic [CS_W-1:0]                        bram_cs,
  output logic [ADDR_W-1:0]                      bram_addr,
  output logic [7:0]                             bram_data,
  output logic                                   bram_wr,
  output logic                                   load_done,
  output logic                                   overflow
);

  localparam int EW = ADDR_W + 1 + CS_W;
  localparam int RW = $clog2(NUM_REGIONS + 1);
  localparam int HW = $clog2(2 * NUM_REGIONS + 1);
  localparam int R  = REORDER_BITS;
  localparam int LW = (ADDR_W > 26) ? ADDR_W : 26;
  // Region index one past the table means "past the last region".
  localparam logic [RW-1:0] NO_REGION = RW'(NUM_REGIONS);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_WRITE} state_t;

  state_t            state, state_d;
  logic              dl_q;
  logic              dl_rise;
  logic [HW-1:0]     hdr_cnt, hdr_cnt_d, hdr_idx;
  logic              hdr_wr;
  logic [15:0]       len   [NUM_REGIONS];
  logic [15:0]       len_d [NUM_REGIONS];
  logic [RW-1:0]     region, region_d, seek_from, seek_region;
  logic [ADDR_W-1:0] offset, offset_d;

  logic [ADDR_W-1:0] cur_base;
  logic              cur_reo;
  logic [CS_W-1:0]   cur_cs;
  logic [15:0]       cur_len;
  logic [ADDR_W-1:0] ro;
  logic [ADDR_W-1:0] sdr_addr_nxt;
  logic              last_byte;

  logic              wait_d, req_d, bram_wr_d, load_done_d, overflow_d;
  logic [ADDR_W-1:0] sdr_addr_d, bram_addr_d;
  logic [15:0]       sdr_data_d;
  logic [1:0]        sdr_be_d;
  logic [CS_W-1:0]   bram_cs_d;
  logic [7:0]        bram_data_d;

  assign dl_rise = ioctl_download & ~dl_q;

  // Decode the table entry of the region currently being filled.
  always_comb begin
    cur_base = '0;
    cur_reo  = 1'b0;
    cur_cs   = '0;
    cur_len  = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (region == RW'(i)) begin
        cur_cs   = region_tbl[i*EW +: CS_W];
        cur_reo  = region_tbl[i*EW + CS_W];
        cur_base = region_tbl[i*EW + CS_W + 1 +: ADDR_W];
        cur_len  = len[i];
      end
    end
  end

  // Offset within region, with the low group bits rotated when reorder is set.
  always_comb begin
    if (cur_reo) ro = {offset[ADDR_W-1:R], offset[R-2:0], offset[R-1]};
    else         ro = offset;
    sdr_addr_nxt = cur_base + ro;
    last_byte    = (LW'(offset) == LW'({cur_len - 16'd1, 10'h3ff}));
  end

  // Header byte capture; a byte coincident with the download edge is byte 0.
  always_comb begin
    len_d   = len;
    hdr_wr  = ioctl_wr && ((state == S_HEADER && ioctl_download) ||
                           (state == S_IDLE && dl_rise));
    hdr_idx = (state == S_IDLE) ? '0 : hdr_cnt;
    if (hdr_wr) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (hdr_idx == HW'(2*i))     len_d[i][15:8] = ioctl_dout;
        if (hdr_idx == HW'(2*i + 1)) len_d[i][7:0]  = ioctl_dout;
      end
    end
  end

  // Next nonempty region at or after seek_from; zero-length regions are skipped.
  always_comb begin
    seek_from   = (state == S_HEADER) ? '0 : region + RW'(1);
    seek_region = NO_REGION;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((RW'(i) >= seek_from) && (len_d[i] != 16'd0)) seek_region = RW'(i);
    end
  end

  // FSM next state and next values of all registered outputs.
  always_comb begin
    state_d     = state;
    hdr_cnt_d   = hdr_cnt;
    region_d    = region;
    offset_d    = offset;
    wait_d      = ioctl_wait;
    req_d       = sdr_req;
    sdr_addr_d  = sdr_addr;
    sdr_data_d  = sdr_data;
    sdr_be_d    = sdr_be;
    bram_cs_d   = bram_cs;
    bram_addr_d = bram_addr;
    bram_data_d = bram_data;
    bram_wr_d   = 1'b0;
    load_done_d = 1'b0;
    overflow_d  = overflow;
    case (state)
      S_IDLE: begin
        if (dl_rise) begin
          state_d    = S_HEADER;
          overflow_d = 1'b0;
          region_d   = '0;
          offset_d   = '0;
          hdr_cnt_d  = ioctl_wr ? HW'(1) : '0;
        end
      end
      S_HEADER: begin
        if (!ioctl_download) begin
          state_d     = S_IDLE;
          load_done_d = 1'b1;
        end else if (ioctl_wr) begin
          if (hdr_cnt == HW'(2*NUM_REGIONS - 1)) begin
            state_d  = S_DATA;
            region_d = seek_region;
            offset_d = '0;
          end else begin
            hdr_cnt_d = hdr_cnt + HW'(1);
          end
        end
      end
      S_DATA: begin
        if (!ioctl_download) begin
          state_d     = S_IDLE;
          load_done_d = 1'b1;
        end else if (ioctl_wr) begin
          if (region == NO_REGION) begin
            overflow_d = 1'b1;
          end else begin
            if (cur_cs != '0) begin
              bram_wr_d   = 1'b1;
              bram_cs_d   = cur_cs;
              bram_addr_d = ro;
              bram_data_d = ioctl_dout;
            end else begin
              req_d      = 1'b1;
              wait_d     = 1'b1;
              sdr_addr_d = sdr_addr_nxt;
              sdr_data_d = {ioctl_dout, ioctl_dout};
              sdr_be_d   = sdr_addr_nxt[0] ? 2'b10 : 2'b01;
              state_d    = S_WRITE;
            end
            if (last_byte) begin
              offset_d = '0;
              region_d = seek_region;
            end else begin
              offset_d = offset + ADDR_W'(1);
            end
          end
        end
      end
      S_WRITE: begin
        if (sdr_ack) begin
          req_d  = 1'b0;
          wait_d = 1'b0;
          if (!ioctl_download) begin
            state_d     = S_IDLE;
            load_done_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, header lengths and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      hdr_cnt    <= '0;
      region     <= '0;
      offset     <= '0;
      for (int i = 0; i < NUM_REGIONS; i++) len[i] <= '0;
      ioctl_wait <= 1'b0;
      sdr_req    <= 1'b0;
      sdr_addr   <= '0;
      sdr_data   <= '0;
      sdr_be     <= '0;
      bram_cs    <= '0;
      bram_addr  <= '0;
      bram_data  <= '0;
      bram_wr    <= 1'b0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_d;
      dl_q       <= ioctl_download;
      hdr_cnt    <= hdr_cnt_d;
      region     <= region_d;
      offset     <= offset_d;
      len        <= len_d;
      ioctl_wait <= wait_d;
      sdr_req    <= req_d;
      sdr_addr   <= sdr_addr_d;
      sdr_data   <= sdr_data_d;
      sdr_be     <= sdr_be_d;
      bram_cs    <= bram_cs_d;
      bram_addr  <= bram_addr_d;
      bram_data  <= bram_data_d;
      bram_wr    <= bram_wr_d;
      load_done  <= load_done_d;
      overflow   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_rom_region_loader.sv
// Testbench for rom_region_loader: a reference model predicts every SDRAM/BRAM
// write and queues it, and a negedge monitor pops and compares each one.
module tb_rom_region_loader;

  localparam int NR = 8;
  localparam int AW = 25;
  localparam int CW = 5;
  localparam int EW = AW + 1 + CW;
  localparam int W  = 1 + CW + AW + 16 + 2;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NR*EW-1:0] region_tbl;
  logic             ioctl_download, ioctl_wr, ioctl_wait;
  logic [7:0]       ioctl_dout;
  logic             sdr_req, sdr_ack;
  logic [AW-1:0]    sdr_addr, bram_addr;
  logic [15:0]      sdr_data;
  logic [1:0]       sdr_be;
  logic [CW-1:0]    bram_cs;
  logic [7:0]       bram_data;
  logic             bram_wr, load_done, overflow;

  rom_region_loader #(.NUM_REGIONS(NR), .ADDR_W(AW), .CS_W(CW), .REORDER_BITS(3)) dut (
    .clk(clk), .reset_n(reset_n), .region_tbl(region_tbl),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .sdr_req(sdr_req), .sdr_ack(sdr_ack),
    .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_be(sdr_be),
    .bram_cs(bram_cs), .bram_addr(bram_addr), .bram_data(bram_data),
    .bram_wr(bram_wr), .load_done(load_done), .overflow(overflow)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int n_sdr = 0, n_bram = 0, n_done = 0, n_done_req = 0;
  int wait_run = 0, last_wait_run = 0;
  logic req_prev = 1'b0;
  logic [W-1:0] held_obs, mon_obs, mon_exp;

  // Monitor: pop on each bram_wr and each new sdr_req; hold-check sdr_* while req is high.
  always @(negedge clk) begin
    if (load_done === 1'b1) begin
      n_done++;
      if (sdr_req === 1'b1) n_done_req++;
    end
    if (ioctl_wait === 1'b1) wait_run++;
    else begin
      if (wait_run > 0) last_wait_run = wait_run;
      wait_run = 0;
    end
    if (bram_wr === 1'b1) begin
      n_bram++;
      vectors++;
      mon_obs = {1'b1, bram_cs, bram_addr, 8'h00, bram_data, 2'b00};
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL bram_write: got %h, expected no write", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          miscompares++;
          $display("FAIL bram_write: got %h expected %h", mon_obs, mon_exp);
        end
      end
    end
    if (sdr_req === 1'b1) begin
      mon_obs = {1'b0, {CW{1'b0}}, sdr_addr, sdr_data, sdr_be};
      vectors++;
      if (!req_prev) begin
        n_sdr++;
        held_obs = mon_obs;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sdr_write: got %h, expected no write", mon_obs);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_obs !== mon_exp) begin
            miscompares++;
            $display("FAIL sdr_write: got %h expected %h", mon_obs, mon_exp);
          end
        end
      end else if (mon_obs !== held_obs) begin
        miscompares++;
        $display("FAIL sdr_stable: got %h held %h", mon_obs, held_obs);
      end
    end
    req_prev = (sdr_req === 1'b1);
  end

  // SDRAM responder: ack after ack_delay cycles of a pending request.
  int ack_delay = 0;
  int req_age = 0;
  initial begin
    sdr_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sdr_ack) sdr_ack = 1'b0;
      else if (sdr_req === 1'b1) begin
        if (req_age >= ack_delay) begin
          sdr_ack = 1'b1;
          req_age = 0;
        end else req_age++;
      end else req_age = 0;
    end
  end

  // ---------------- reference model ----------------
  logic [AW-1:0] t_base[NR];
  logic          t_reo[NR];
  logic [CW-1:0] t_cs[NR];
  int m_len[NR];
  int m_region, m_offset;

  function automatic logic [AW-1:0] model_ro(input logic [AW-1:0] o, input logic reo);
    if (!reo) return o;
    return {o[AW-1:3], o[1:0], o[2]};
  endfunction

  task automatic clear_table();
    region_tbl = '0;
    for (int i = 0; i < NR; i++) begin
      t_base[i] = '0; t_reo[i] = 1'b0; t_cs[i] = '0; m_len[i] = 0;
    end
  endtask

  task automatic set_region(input int i, input logic [AW-1:0] base, input logic reo,
                            input logic [CW-1:0] cs);
    t_base[i] = base; t_reo[i] = reo; t_cs[i] = cs;
    region_tbl[i*EW +: EW] = {base, reo, cs};
  endtask

  task automatic model_advance();
    int j;
    j = m_region + 1;
    m_region = NR;
    for (int k = NR - 1; k >= j; k--) if (m_len[k] != 0) m_region = k;
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1; one strobe cycle plus one gap cycle per byte.
  task automatic send_raw(input logic [7:0] b);
    int guard;
    guard = 0;
    while (ioctl_wait === 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_timeout: ioctl_wait still %b after %0d cycles, expected 0", ioctl_wait, guard);
    end
    ioctl_wr = 1'b1; ioctl_dout = b;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    @(posedge clk); #1;
  endtask

  // Payload byte; ovr replaces the model's SDRAM address with a literal expectation.
  task automatic send_payload(input logic [7:0] b, input logic ovr, input logic [AW-1:0] ovr_addr);
    logic [AW-1:0] ro, a;
    if (m_region < NR) begin
      ro = model_ro(AW'(m_offset), t_reo[m_region]);
      if (t_cs[m_region] != '0) exp_q.push_back({1'b1, t_cs[m_region], ro, 8'h00, b, 2'b00});
      else begin
        a = ovr ? ovr_addr : t_base[m_region] + ro;
        exp_q.push_back({1'b0, {CW{1'b0}}, a, b, b, a[0] ? 2'b10 : 2'b01});
      end
      if (m_offset == m_len[m_region] * 1024 - 1) begin
        m_offset = 0;
        model_advance();
      end else m_offset++;
    end
    send_raw(b);
  endtask

  task automatic start_download(input logic same);
    int first;
    logic [7:0] hb;
    first = 0;
    ioctl_download = 1'b1;
    if (same) begin
      ioctl_wr = 1'b1; ioctl_dout = 8'(m_len[0] >> 8);
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
      @(posedge clk); #1;
      first = 1;
    end else begin
      @(posedge clk); #1;
    end
    for (int i = first; i < 2 * NR; i++) begin
      hb = (i % 2 == 0) ? 8'(m_len[i/2] >> 8) : 8'(m_len[i/2]);
      send_raw(hb);
    end
    m_region = -1;
    m_offset = 0;
    model_advance();
  endtask

  task automatic end_download(input string name);
    int d0, guard;
    d0 = n_done;
    guard = 0;
    ioctl_download = 1'b0;
    while (n_done == d0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (n_done != d0 + 1) begin
      miscompares++;
      $display("FAIL %s load_done: got %0d pulses expected 1", name, n_done - d0);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s pending: got %0d unissued writes expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (ioctl_wait !== 1'b0) begin miscompares++; $display("FAIL reset_ioctl_wait: got %b expected 0", ioctl_wait); end
    vectors++; if (sdr_req !== 1'b0)    begin miscompares++; $display("FAIL reset_sdr_req: got %b expected 0", sdr_req); end
    vectors++; if (sdr_addr !== '0)     begin miscompares++; $display("FAIL reset_sdr_addr: got %h expected 0", sdr_addr); end
    vectors++; if (sdr_data !== '0)     begin miscompares++; $display("FAIL reset_sdr_data: got %h expected 0", sdr_data); end
    vectors++; if (sdr_be !== '0)       begin miscompares++; $display("FAIL reset_sdr_be: got %b expected 0", sdr_be); end
    vectors++; if (bram_cs !== '0)      begin miscompares++; $display("FAIL reset_bram_cs: got %h expected 0", bram_cs); end
    vectors++; if (bram_addr !== '0)    begin miscompares++; $display("FAIL reset_bram_addr: got %h expected 0", bram_addr); end
    vectors++; if (bram_data !== '0)    begin miscompares++; $display("FAIL reset_bram_data: got %h expected 0", bram_data); end
    vectors++; if (bram_wr !== 1'b0)    begin miscompares++; $display("FAIL reset_bram_wr: got %b expected 0", bram_wr); end
    vectors++; if (load_done !== 1'b0)  begin miscompares++; $display("FAIL reset_load_done: got %b expected 0", load_done); end
    vectors++; if (overflow !== 1'b0)   begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({ioctl_wait, sdr_req, bram_wr, load_done} !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b expected 0000", {ioctl_wait, sdr_req, bram_wr, load_done});
    end
  endtask

  task automatic test_sdram_linear();
    int s0;
    logic [AW-1:0] lit;
    clear_table();
    set_region(0, 25'h0, 1'b0, '0);
    m_len[0] = 1;
    ack_delay = 0;
    s0 = n_sdr;
    start_download(1'b0);
    for (int i = 0; i < 1024; i++) begin
      lit = AW'(i);
      send_payload(8'($urandom_range(0, 255)), (i < 4), lit);
    end
    end_download("sdram_linear");
    vectors++;
    if (n_sdr - s0 != 1024) begin miscompares++; $display("FAIL sdram_linear_count: got %0d expected 1024", n_sdr - s0); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL sdram_linear_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_reorder();
    int lit_off[8];
    lit_off = '{0, 2, 4, 6, 1, 3, 5, 7};
    clear_table();
    set_region(1, 25'h40_0000, 1'b1, '0);
    m_len[1] = 1;
    ack_delay = 1;
    start_download(1'b0);
    for (int i = 0; i < 1024; i++)
      send_payload(8'($urandom_range(0, 255)), (i < 8), 25'h40_0000 + AW'(lit_off[i % 8]));
    end_download("reorder");
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reorder_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_bram();
    int s0, b0;
    clear_table();
    set_region(2, 25'h1_2345, 1'b0, 5'b00010);
    m_len[2] = 1;
    s0 = n_sdr;
    b0 = n_bram;
    start_download(1'b1);
    for (int i = 0; i < 1024; i++) send_payload(8'($urandom_range(0, 255)), 1'b0, '0);
    end_download("bram");
    vectors++;
    if (n_bram - b0 != 1024) begin miscompares++; $display("FAIL bram_count: got %0d expected 1024", n_bram - b0); end
    vectors++;
    if (n_sdr - s0 != 0) begin miscompares++; $display("FAIL bram_sdr_count: got %0d expected 0", n_sdr - s0); end
  endtask

  task automatic test_skip_overflow();
    int s0;
    clear_table();
    set_region(0, 25'h1000, 1'b0, '0);
    set_region(1, 25'h2000, 1'b0, '0);
    set_region(2, 25'h10_0000, 1'b0, '0);
    m_len[0] = 1; m_len[1] = 0; m_len[2] = 2;
    ack_delay = 0;
    s0 = n_sdr;
    start_download(1'b0);
    for (int i = 0; i < 3072; i++)
      send_payload(8'($urandom_range(0, 255)), (i == 1024 || i == 0), (i == 0) ? 25'h1000 : 25'h10_0000);
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL skip_overflow_early: got %b expected 0", overflow); end
    for (int i = 0; i < 4; i++) send_payload(8'($urandom_range(0, 255)), 1'b0, '0);
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL skip_overflow_set: got %b expected 1", overflow); end
    end_download("skip_overflow");
    vectors++;
    if (n_sdr - s0 != 3072) begin miscompares++; $display("FAIL skip_count: got %0d expected 3072", n_sdr - s0); end
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_ack_delay();
    int guard, r0;
    clear_table();
    set_region(0, 25'h20_0000, 1'b0, '0);
    m_len[0] = 1;
    ack_delay = 5;
    r0 = n_done_req;
    start_download(1'b0);
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL overflow_cleared: got %b expected 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      last_wait_run = 0;
      send_payload(8'($urandom_range(0, 255)), 1'b0, '0);
      guard = 0;
      while (ioctl_wait === 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
      @(negedge clk); #1;
      vectors++;
      if (last_wait_run != 6) begin miscompares++; $display("FAIL ack_delay_wait: got %0d cycles expected 6", last_wait_run); end
      @(posedge clk); #1;
    end
    // Drop download while the final write is still waiting for its ack.
    last_wait_run = 0;
    send_payload(8'hA5, 1'b0, '0);
    end_download("ack_delay");
    vectors++;
    if (last_wait_run != 6) begin miscompares++; $display("FAIL ack_delay_last_wait: got %0d cycles expected 6", last_wait_run); end
    vectors++;
    if (n_done_req != r0) begin miscompares++; $display("FAIL done_during_req: got %0d expected 0", n_done_req - r0); end
    ack_delay = 0;
  endtask

  task automatic test_header_abort();
    int s0, b0;
    clear_table();
    set_region(0, 25'h0, 1'b0, '0);
    s0 = n_sdr;
    b0 = n_bram;
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send_raw(8'($urandom_range(1, 255)));
    end_download("header_abort");
    vectors++;
    if ((n_sdr - s0) + (n_bram - b0) != 0) begin
      miscompares++;
      $display("FAIL header_abort_writes: got %0d expected 0", (n_sdr - s0) + (n_bram - b0));
    end
  endtask

  task automatic test_reset_mid_write();
    int d0;
    clear_table();
    set_region(0, 25'h0, 1'b0, '0);
    m_len[0] = 1;
    ack_delay = 8;
    start_download(1'b0);
    send_payload(8'h3C, 1'b0, '0);
    @(posedge clk); #1;
    d0 = n_done;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk);
    vectors++; if (sdr_req !== 1'b0)    begin miscompares++; $display("FAIL rst_mid_sdr_req: got %b expected 0", sdr_req); end
    vectors++; if (ioctl_wait !== 1'b0) begin miscompares++; $display("FAIL rst_mid_wait: got %b expected 0", ioctl_wait); end
    vectors++; if (sdr_addr !== '0)     begin miscompares++; $display("FAIL rst_mid_sdr_addr: got %h expected 0", sdr_addr); end
    vectors++; if (sdr_data !== '0)     begin miscompares++; $display("FAIL rst_mid_sdr_data: got %h expected 0", sdr_data); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (n_done != d0) begin miscompares++; $display("FAIL rst_mid_load_done: got %0d pulses expected 0", n_done - d0); end
    exp_q.delete();
    ack_delay = 0;
    set_region(0, 25'h00_0100, 1'b0, '0);
    start_download(1'b0);
    for (int i = 0; i < 16; i++) send_payload(8'($urandom_range(0, 255)), (i == 0), 25'h00_0100);
    end_download("restart");
  endtask

  initial begin
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_dout = 8'h00;
    clear_table();
    test_reset();
    test_sdram_linear();
    test_reorder();
    test_bram();
    test_skip_overflow();
    test_ack_delay();
    test_header_abort();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
